// File: rtl/preg_freelist.sv
// Physical-register free list for a two-wide rename stage: circular buffer with
// speculative and architectural heads, flush recovery and a sticky overflow flag.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// NORMAL   | allocation allowed when at least two entries are free
// RECOVER  | one-cycle bubble after a flush while spec_head settles on arch_head
module preg_freelist #(
    parameter int PREG_NUM = 64,
    parameter int FL_DEPTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       alloc0_req,
    input  logic       alloc1_req,
    output logic       alloc_ready,
    output logic [5:0] alloc0_preg,
    output logic [5:0] alloc1_preg,
    input  logic       free0_valid,
    input  logic       free1_valid,
    input  logic [5:0] free0_preg,
    input  logic [5:0] free1_preg,
    input  logic       commits0_valid,
    input  logic       commits0_need_to_wb,
    input  logic       commits1_valid,
    input  logic       commits1_need_to_wb,
    input  logic       flush_valid,
    output logic [5:0] free_count,
    output logic       overflow_err
);

    localparam logic ST_NORMAL  = 1'b0;
    localparam logic ST_RECOVER = 1'b1;

    logic [5:0] fl_buf [FL_DEPTH];
    logic [5:0] spec_head;
    logic [5:0] arch_head;
    logic [5:0] tail;
    logic       state;
    logic       state_next;

    logic [4:0] head_idx;
    logic [4:0] head_idx_p1;
    logic [4:0] tail_idx;
    logic [4:0] tail_idx_free1;
    logic [1:0] alloc_cnt;
    logic [1:0] push_cnt;
    logic [1:0] commit_cnt;
    logic [5:0] arch_head_next;
    logic       push_overflows;

    assign head_idx       = spec_head[4:0];
    assign head_idx_p1    = head_idx + 5'd1;
    assign tail_idx       = tail[4:0];
    assign tail_idx_free1 = tail_idx + {4'd0, free0_valid};

    assign alloc_cnt  = {1'b0, alloc0_req} + {1'b0, alloc1_req};
    assign push_cnt   = {1'b0, free0_valid} + {1'b0, free1_valid};
    assign commit_cnt = {1'b0, commits0_valid & commits0_need_to_wb}
                      + {1'b0, commits1_valid & commits1_need_to_wb};

    assign arch_head_next = arch_head + {4'd0, commit_cnt};

    assign free_count  = tail - spec_head;
    assign alloc_ready = (state == ST_NORMAL) && !flush_valid && (free_count >= 6'd2);

    assign alloc0_preg = fl_buf[head_idx];
    assign alloc1_preg = alloc0_req ? fl_buf[head_idx_p1] : fl_buf[head_idx];

    // Overflow is judged against the occupancy seen at the start of the cycle.
    assign push_overflows = ({1'b0, free_count} + {5'd0, push_cnt}) > 7'(FL_DEPTH);

    always_comb begin
        state_next = state;
        case (state)
            ST_NORMAL:  state_next = flush_valid ? ST_RECOVER : ST_NORMAL;
            ST_RECOVER: state_next = flush_valid ? ST_RECOVER : ST_NORMAL;
            default:    state_next = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_buf[i] <= 6'(PREG_NUM - FL_DEPTH + i);
            end
        end else begin
            if (free0_valid) begin
                fl_buf[tail_idx] <= free0_preg;
            end
            if (free1_valid) begin
                fl_buf[tail_idx_free1] <= free1_preg;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spec_head    <= 6'd0;
            arch_head    <= 6'd0;
            tail         <= 6'(FL_DEPTH);
            state        <= ST_NORMAL;
            overflow_err <= 1'b0;
        end else begin
            state     <= state_next;
            arch_head <= arch_head_next;
            tail      <= tail + {4'd0, push_cnt};
            if (push_overflows) begin
                overflow_err <= 1'b1;
            end
            // A flush rewinds to the committed point, including this cycle's commits.
            if (flush_valid) begin
                spec_head <= arch_head_next;
            end else if (alloc_ready) begin
                spec_head <= spec_head + {4'd0, alloc_cnt};
            end
        end
    end

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed scenarios followed by random
// traffic, compared against a pointer/array reference model.
module tb_preg_freelist;

    logic       clock;
    logic       reset_n;
    logic       alloc0_req, alloc1_req;
    logic       alloc_ready;
    logic [5:0] alloc0_preg, alloc1_preg;
    logic       free0_valid, free1_valid;
    logic [5:0] free0_preg, free1_preg;
    logic       commits0_valid, commits0_need_to_wb;
    logic       commits1_valid, commits1_need_to_wb;
    logic       flush_valid;
    logic [5:0] free_count;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded-style counters kept modulo 64.
    int m_mem [32];
    int m_spec, m_arch, m_tail;
    bit m_rec, m_ovf;

    preg_freelist #(.PREG_NUM(64), .FL_DEPTH(32)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .alloc0_req          (alloc0_req),
        .alloc1_req          (alloc1_req),
        .alloc_ready         (alloc_ready),
        .alloc0_preg         (alloc0_preg),
        .alloc1_preg         (alloc1_preg),
        .free0_valid         (free0_valid),
        .free1_valid         (free1_valid),
        .free0_preg          (free0_preg),
        .free1_preg          (free1_preg),
        .commits0_valid      (commits0_valid),
        .commits0_need_to_wb (commits0_need_to_wb),
        .commits1_valid      (commits1_valid),
        .commits1_need_to_wb (commits1_need_to_wb),
        .flush_valid         (flush_valid),
        .free_count          (free_count),
        .overflow_err        (overflow_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_cnt();
        return (m_tail - m_spec) & 63;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
        m_spec = 0;
        m_arch = 0;
        m_tail = 32;
        m_rec  = 0;
        m_ovf  = 0;
    endtask

    task automatic drive(input logic r0, input logic r1,
                         input logic f0, input logic [5:0] p0,
                         input logic f1, input logic [5:0] p1,
                         input logic c0, input logic w0,
                         input logic c1, input logic w1,
                         input logic fl);
        alloc0_req = r0;  alloc1_req = r1;
        free0_valid = f0; free0_preg = p0;
        free1_valid = f1; free1_preg = p1;
        commits0_valid = c0; commits0_need_to_wb = w0;
        commits1_valid = c1; commits1_need_to_wb = w1;
        flush_valid = fl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_model();
        int  cnt;
        bit  rdy;
        int  a0, a1;
        cnt = m_cnt();
        rdy = !m_rec && !flush_valid && (cnt >= 2);
        a0  = m_mem[m_spec % 32];
        a1  = alloc0_req ? m_mem[(m_spec + 1) % 32] : a0;
        chk("model_alloc_ready", 32'(alloc_ready), 32'(rdy));
        chk("model_free_count", 32'(free_count), 32'(cnt));
        chk("model_alloc0_preg", 32'(alloc0_preg), 32'(a0));
        chk("model_alloc1_preg", 32'(alloc1_preg), 32'(a1));
        chk("model_overflow_err", 32'(overflow_err), 32'(m_ovf));
    endtask

    task automatic tick();
        int cnt, npush, ncommit;
        bit rdy;
        @(posedge clock);
        cnt     = m_cnt();
        npush   = int'(free0_valid) + int'(free1_valid);
        ncommit = int'(commits0_valid & commits0_need_to_wb)
                + int'(commits1_valid & commits1_need_to_wb);
        rdy     = !m_rec && !flush_valid && (cnt >= 2);
        if (cnt + npush > 32) m_ovf = 1;
        if (free0_valid) m_mem[m_tail % 32] = int'(free0_preg);
        if (free1_valid) m_mem[(m_tail + int'(free0_valid)) % 32] = int'(free1_preg);
        m_tail = (m_tail + npush) & 63;
        m_arch = (m_arch + ncommit) & 63;
        if (flush_valid) m_spec = m_arch;
        else if (rdy) m_spec = (m_spec + int'(alloc0_req) + int'(alloc1_req)) & 63;
        m_rec = flush_valid;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        #1;
        m_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int inflight, room;
        logic r0, r1, f0, f1, c0, w0, c1, w1, fl;
        logic [5:0] p0, p1;

        reset_n = 1'b0;
        idle();
        m_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Post-reset view and two back-to-back dual allocations.
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_count", 32'(free_count), 32'd32);
        chk("rst_a0", 32'(alloc0_preg), 32'd32);
        chk("rst_a1", 32'(alloc1_preg), 32'd33);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("dual2_a0", 32'(alloc0_preg), 32'd34);
        chk("dual2_a1", 32'(alloc1_preg), 32'd35);
        chk("dual2_count", 32'(free_count), 32'd30);
        idle();
        tick();

        // Slot 1 alone takes the head entry.
        do_reset();
        drive(0, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("slot1_a1", 32'(alloc1_preg), 32'd32);
        tick();
        idle();
        check_model();
        chk("slot1_count", 32'(free_count), 32'd31);
        chk("slot1_head", 32'(alloc0_preg), 32'd33);

        // Drain to empty, stall, then refill from frees.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
            check_model();
            tick();
        end
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("last2_count", 32'(free_count), 32'd2);
        chk("last2_a0", 32'(alloc0_preg), 32'd62);
        chk("last2_a1", 32'(alloc1_preg), 32'd63);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("empty_ready", 32'(alloc_ready), 32'd0);
        chk("empty_count", 32'(free_count), 32'd0);
        tick();
        drive(0, 0, 1, 6'd5, 1, 6'd7, 0, 0, 0, 0, 0);
        check_model();
        chk("stall_count", 32'(free_count), 32'd0);
        chk("free_not_visible_ready", 32'(alloc_ready), 32'd0);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("refill_count", 32'(free_count), 32'd2);
        chk("refill_a0", 32'(alloc0_preg), 32'd5);
        chk("refill_a1", 32'(alloc1_preg), 32'd7);
        tick();

        // Flush with a same-cycle commit rewinds to arch_head+1.
        do_reset();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 1, 1, 0, 0, 1);
        check_model();
        chk("flush_ready", 32'(alloc_ready), 32'd0);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("recover_ready", 32'(alloc_ready), 32'd0);
        tick();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("post_flush_ready", 32'(alloc_ready), 32'd1);
        chk("post_flush_a0", 32'(alloc0_preg), 32'd33);
        chk("post_flush_a1", 32'(alloc1_preg), 32'd34);
        chk("post_flush_count", 32'(free_count), 32'd31);
        tick();

        // Asynchronous reset in the middle of RECOVER.
        do_reset();
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 1);
        tick();
        idle();
        check_model();
        chk("mid_recover_ready", 32'(alloc_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_ready", 32'(alloc_ready), 32'd1);
        chk("async_rst_count", 32'(free_count), 32'd32);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1, 1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("async_rst_a0", 32'(alloc0_preg), 32'd32);
        chk("async_rst_a1", 32'(alloc1_preg), 32'd33);
        idle();

        // Push into a full list sets a sticky error cleared only by reset.
        do_reset();
        drive(0, 0, 1, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0);
        check_model();
        chk("ovf_before", 32'(overflow_err), 32'd0);
        tick();
        idle();
        check_model();
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(free_count), 32'd33);
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        do_reset();
        #1;
        chk("ovf_cleared", 32'(overflow_err), 32'd0);

        // Random traffic with realistic commit/free volumes.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            inflight = (m_spec - m_arch) & 63;
            room     = 32 - ((m_tail - m_arch) & 63);
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            f0 = (room >= 1) && ($urandom_range(0, 2) != 0);
            f1 = (room >= int'(f0) + 1) && ($urandom_range(0, 2) != 0);
            p0 = 6'($urandom_range(0, 63));
            p1 = 6'($urandom_range(0, 63));
            c0 = 1'($urandom_range(0, 1));
            w0 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            if (int'(c0 & w0) + int'(c1 & w1) > inflight) begin
                c0 = 1'b0;
                c1 = 1'b0;
            end
            fl = ($urandom_range(0, 15) == 0);
            drive(r0, r1, f0, p0, f1, p1, c0, w0, c1, w1, fl);
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter PREG_NUM, default 64, meaning the number of physical registers.
REQ-002 SHALL have parameter FL_DEPTH, default 32, meaning the number of free-list entries (PREG_NUM-32).
REQ-003 SHALL have port clock  input  1  clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alloc0_req  input  1  rename slot 0 requests a new physical register.
REQ-006 SHALL have port alloc1_req  input  1  rename slot 1 requests a new physical register.
REQ-007 SHALL have port alloc_ready  output  1  allocation is accepted this cycle.
REQ-008 SHALL have port alloc0_preg  output  6  preg granted to slot 0.
REQ-009 SHALL have port alloc1_preg  output  6  preg granted to slot 1.
REQ-010 SHALL have port free0_valid / free1_valid  input  1 each  commit releases an old prd.
REQ-011 SHALL have port free0_preg / free1_preg  input  6 each  preg being released.
REQ-012 SHALL have port commits0_valid, commits0_need_to_wb, commits1_valid, commits1_need_to_wb  input  1 each  committed instruction consumed one allocation.
REQ-013 SHALL have port flush_valid  input  1  pipeline redirect; discard speculative allocations.
REQ-014 SHALL have port free_count  output  6  number of free entries (0..FL_DEPTH).
REQ-015 SHALL have port overflow_err  output  1  sticky: push attempted while full.

Function
REQ-016 SHALL hold a circular buffer of FL_DEPTH 6-bit entries, with spec head, arch head and tail pointers, each 6 bits (5-bit index plus wrap bit).
REQ-017 SHALL define free_count = tail - spec_head, modulo 64.
REQ-018 SHALL have a 2-state FSM: NORMAL and RECOVER; flush_valid in any state -> RECOVER; RECOVER -> NORMAL after exactly 1 cycle unless flush_valid is high again.
REQ-019 SHALL drive alloc_ready = state==NORMAL & ~flush_valid & free_count>=2, combinationally.
REQ-020 SHALL drive alloc0_preg = buf[spec_head].
REQ-021 SHALL drive alloc1_preg = alloc0_req ? buf[spec_head+1] : buf[spec_head].
REQ-022 SHALL be zero-latency on the outputs: both are read combinationally from registered state and are valid in the same cycle as the request.
REQ-023 SHALL advance spec_head by (alloc0_req + alloc1_req) when alloc_ready; a request without alloc_ready SHALL NOT change state, and the requester retries.
REQ-024 SHALL write free0_preg at buf[tail] and free1_preg at buf[tail+free0_valid], then advance tail by free0_valid+free1_valid; frees SHALL be accepted in every state, including flush and RECOVER cycles.
REQ-025 SHALL advance arch_head by (commits0_valid&commits0_need_to_wb) + (commits1_valid&commits1_need_to_wb) every cycle.
REQ-026 SHALL load spec_head with the next-cycle arch_head value, including same-cycle commits, on flush_valid; allocation SHALL be suppressed that cycle.
REQ-027 SHALL wrap all pointer arithmetic modulo 64; buffer index = pointer[4:0].
REQ-028 SHALL set overflow_err if a push would make free_count > FL_DEPTH; the push SHALL still occur, and overflow_err SHALL clear only on reset.
REQ-029 SHALL give allocation priority over nothing: frees pushed in cycle N SHALL be visible to allocation in cycle N+1, not N.

Reset
REQ-030 SHALL apply on reset_n low, asynchronously: buf[i] = 32+i, spec_head = arch_head = 0, tail = 32 (wrap bit set), state = NORMAL, overflow_err = 0.
REQ-031 SHALL therefore show free_count = 32, alloc_ready = 1 (with flush_valid low), alloc0_preg = 32, alloc1_preg = 33 (with alloc0_req high) immediately after reset.
REQ-032 SHALL have reset asserted mid-flush or mid-RECOVER return all state to REQ-030 values with no residual effect.

Verification
REQ-033 SHALL cover: reset, alloc0_req=alloc1_req=1 for one cycle -> grants 32/33; next cycle grants 34/35, free_count=30.
REQ-034 SHALL cover: after reset, alloc1_req only -> alloc1_preg=32, spec_head+1, free_count=31.
REQ-035 SHALL cover: allocate 30 entries (free_count=2), then dual request -> grant 62/63, free_count=0; next request -> alloc_ready=0 and no state change.
REQ-036 SHALL cover: free_count=0 with free0_preg=5 and free1_preg=7 -> next cycle free_count=2, grants 5/7.
REQ-037 SHALL cover: allocate 4 (32..35), commit 1 with need_to_wb in the same cycle as flush_valid -> spec_head=1, alloc_ready=0 for 2 cycles (flush + RECOVER), then grants 33/34.
REQ-038 SHALL cover: at reset state, free0_valid=1 -> overflow_err=1, which stays set until reset_n is pulsed low.
